// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a producer/consumer pair and sync_fifo_param.
// master = the side driving requests, slave = the FIFO.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr;
  logic [WIDTH-1:0] data_in;
  logic             rd;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             flush;
  logic             err_clr;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, data_in, rd, flush, err_clr,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd, flush, err_clr,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with exact count, almost flags, registered read,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic             clk,
  input  logic             reset,
  sync_fifo_param_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] data_out_reg;
  logic             rd_valid_reg;
  logic             overflow_reg, underflow_reg;
  logic             full, empty, rd_ok, wr_ok;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // Flush suppresses both requests, so they neither act nor raise errors.
  assign rd_ok = bus.rd & ~empty & ~bus.flush;
  assign wr_ok = bus.wr & (~full | rd_ok) & ~bus.flush;

  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      data_out_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      rd_valid_reg <= rd_ok;
      if (wr_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (rd_ok) begin
        data_out_reg <= mem[rd_ptr_reg];
        rd_ptr_reg   <= ptr_inc(rd_ptr_reg);
      end
    end
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.wr & ~wr_ok & ~bus.flush)  overflow_reg <= 1'b1;
      else if (bus.err_clr)              overflow_reg <= 1'b0;
      if (bus.rd & ~rd_ok & ~bus.flush)  underflow_reg <= 1'b1;
      else if (bus.err_clr)              underflow_reg <= 1'b0;
    end
  end

  assign bus.data_out     = data_out_reg;
  assign bus.rd_valid     = rd_valid_reg;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_reg >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_reg <= CW'(AE_LEVEL));
  assign bus.count        = count_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (WIDTH=8, DEPTH=5, AF=4, AE=1).
module tb_sync_fifo_param;
  localparam int DEPTH = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mq[$];
  logic [7:0] sb_q[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_dout  = 8'h00;
  logic       m_ovf   = 1'b0;
  logic       m_udf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] d,
                      input logic rr, input logic fl, input logic ec);
    logic rd_ok, wr_ok;
    reset = r; bus.wr = w; bus.data_in = d; bus.rd = rr; bus.flush = fl; bus.err_clr = ec;
    if (r) begin
      mq.delete(); sb_q.delete();
      m_valid = 1'b0; m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (fl) begin
      mq.delete();
      m_valid = 1'b0;
      if (ec) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      rd_ok = rr && (mq.size() != 0);
      wr_ok = w && ((mq.size() != DEPTH) || rd_ok);
      if (rd_ok) begin
        m_dout = mq.pop_front();
        sb_q.push_back(m_dout);
      end
      m_valid = rd_ok;
      if (wr_ok) mq.push_back(d);
      if (w && !wr_ok) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
      if (rr && !rd_ok) m_udf = 1'b1; else if (ec) m_udf = 1'b0;
    end
    @(posedge clk);
    #1;
    check("count",        32'(bus.count),        32'(mq.size()));
    check("full",         32'(bus.full),         32'(mq.size() == DEPTH));
    check("empty",        32'(bus.empty),        32'(mq.size() == 0));
    check("almost_full",  32'(bus.almost_full),  32'(mq.size() >= 4));
    check("almost_empty", 32'(bus.almost_empty), 32'(mq.size() <= 1));
    check("overflow",     32'(bus.overflow),     32'(m_ovf));
    check("underflow",    32'(bus.underflow),    32'(m_udf));
    check("rd_valid",     32'(bus.rd_valid),     32'(m_valid));
    check("data_out",     32'(bus.data_out),     32'(m_dout));
    if (bus.rd_valid) begin
      if (sb_q.size() == 0) check("sb_pop", 32'(sb_q.size()), 32'd1);
      else check("rd_data", 32'(bus.data_out), 32'(sb_q.pop_front()));
    end
    $display("t=%0t rst=%b wr=%b din=%02h rd=%b fl=%b ec=%b -> cnt=%0d dout=%02h v=%b ovf=%b udf=%b",
             $time, r, w, d, rr, fl, ec, bus.count, bus.data_out, bus.rd_valid,
             bus.overflow, bus.underflow);
  endtask

  task automatic wr_op(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_op();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bus.wr = 1'b0; bus.data_in = 8'h00; bus.rd = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;

    // Reset held two cycles with requests active
    step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);

    // Fill, overflow, drain, then two write/read rounds to wrap pointers
    for (int i = 0; i < 5; i++) wr_op(8'(8'h10 + i));
    wr_op(8'hEE);
    for (int i = 0; i < 5; i++) rd_op();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) wr_op(8'(8'h50 + 3 * k + i));
      for (int i = 0; i < 3; i++) rd_op();
    end

    // Simultaneous access at full
    for (int i = 0; i < 5; i++) wr_op(8'(8'h60 + i));
    step(1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) rd_op();

    // Simultaneous access at empty, then read the new word
    step(1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    rd_op();

    // Flush overrides wr/rd at count 3
    for (int i = 0; i < 3; i++) wr_op(8'(8'h40 + i));
    step(1'b0, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0);
    wr_op(8'h44);
    rd_op();

    // Error clear racing a new overflow
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) wr_op(8'(8'h70 + i));
    wr_op(8'h99);
    step(1'b0, 1'b1, 8'h9A, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Reset mid-stream, then immediate write and read
    step(1'b1, 1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    wr_op(8'h5A);
    rd_op();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next generation of the team's byte FIFO. Configurable data width and depth (including non-power-of-two depths), exact fill count, programmable almost-full/almost-empty thresholds, registered read data with a valid strobe, synchronous flush, and sticky overflow/underflow error flags. Sits between a producer and a consumer in the same clock domain, for example in front of a UART/SPI transmitter or after a packet parser.

## Interface

- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 8: number of storage entries, ≥2; need not be a power of two.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- CW (derived, not overridable): $clog2(DEPTH+1).

Ports:

- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- wr, input, 1: write request.
- data_in, input, WIDTH: write data, sampled with wr.
- rd, input, 1: read request.
- data_out, output, WIDTH: registered read data.
- rd_valid, output, 1: data_out was loaded by the previous edge.
- flush, input, 1: synchronous empty-the-FIFO.
- err_clr, input, 1: clears the sticky error flags.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count ≥ AF_LEVEL.
- almost_empty, output, 1: count ≤ AE_LEVEL.
- count, output, CW: number of stored words.
- overflow, output, 1: sticky; a write was dropped.
- underflow, output, 1: sticky; a read was dropped.

## Operation

- **Storage:** DEPTH×WIDTH register array, wr_ptr and rd_ptr in the range 0..DEPTH-1, and a count register of width CW. All flags decode combinationally from the registered count, so they are glitch-free.
- **Pointer wrap:** a pointer at DEPTH-1 advances to 0. Do not rely on natural binary rollover.
- **Write acceptance:** wr_ok = wr & (!full | rd_ok).
  - On wr_ok: mem[wr_ptr] <= data_in and wr_ptr advances.
- **Read acceptance:** rd_ok = rd & !empty.
  - On rd_ok: data_out <= mem[rd_ptr], rd_ptr advances, and rd_valid <= 1. Otherwise rd_valid <= 0 and data_out holds.
- **Count update:** count <= count + wr_ok − rd_ok.
- **Simultaneous wr and rd:**
  - When full: both are accepted, count stays DEPTH, and the oldest word is read out.
  - When empty: the read is rejected (underflow sets), the write is accepted, and count becomes 1. There is no fall-through; the new word is readable next cycle.
  - Otherwise: both are accepted and count is unchanged.
- **Errors:**
  - overflow <= 1 on wr & !wr_ok.
  - underflow <= 1 on rd & !rd_ok.
  - err_clr clears both. If err_clr and a new error event occur in the same cycle, the set wins.
  - A rejected access never changes pointers, memory, count or data_out.
- **Flush:**
  - Effects: wr_ptr, rd_ptr and count go to 0, and rd_valid goes to 0.
  - Retained: data_out, the error flags and the memory contents.
  - Priority: flush overrides wr/rd in the same cycle. Those requests are neither performed nor flagged as errors.
- **Priority order:** reset > flush > normal operation.
- **Reset values:**
  - Pointers and count are 0.
  - data_out = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1 (AE_LEVEL ≥ 0), almost_full = 0.
  - Memory is not reset; its contents are don't-care and unobservable.

## Timing

- **Write-to-read latency:** a word written at edge N can be requested by rd in the cycle after N. It appears on data_out after edge N+1 at the earliest, with rd_valid high in that same cycle.
- **Read latency:** 1 cycle from the rd_ok edge to data_out/rd_valid.
- **Flag latency:** full, empty, almost_* and count reflect an access in the cycle after its edge. There is no combinational path from wr or rd to any output.
- **Throughput:** one write and one read per cycle sustained at any fill level, including full and empty boundaries (subject to the rules above).
- **Reset mid-stream:** at the reset edge, all in-flight state is discarded. The first post-reset write is accepted on the cycle after reset deasserts.

## Test plan

All tests use WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1.

- **Reset:** assert reset for 2 cycles with wr=rd=1 → empty=1, count=0, data_out=0x00, rd_valid=0, overflow=0, underflow=0.
- **Fill and wrap:**
  - Write 0x10..0x14 → count=5, full=1, almost_full became 1 at count=4.
  - A 6th write of 0xEE → overflow=1 and count stays 5.
  - Read 5 → data_out 0x10..0x14 in order, each with rd_valid.
  - Write 3 more and read them back, which wraps the pointers past 4 → 0 with correct data.
- **Simultaneous access at full:** when full, hold wr=rd=1 with data 0x20,0x21 → count stays 5, the oldest words are read out, and no overflow occurs.
- **Simultaneous access at empty:** when empty, wr=rd=1 with 0x33 → underflow=1, count=1, rd_valid=0. The next rd returns 0x33.
- **Flush priority:**
  - At count=3, flush with wr=rd=1 → count=0, empty=1, rd_valid=0, and the error flags are unchanged.
  - A subsequent write of 0x44 then a read returns 0x44.
- **Error clear race:** with overflow=1, assert err_clr together with a full-FIFO write (rd=0) → overflow stays 1. err_clr alone on the next cycle → overflow=0.
